// File: rtl/hermes_route_allocator_pkg.sv
// Shared types for the Hermes route allocator: port numbering and FSM states.
package hermes_route_allocator_pkg;

  localparam int HERMES_NPORT = 5;
  localparam int HERMES_PW    = 3;

  typedef enum logic [2:0] {
    EAST  = 3'd0,
    WEST  = 3'd1,
    NORTH = 3'd2,
    SOUTH = 3'd3,
    LOCAL = 3'd4
  } hermes_port_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    ROUTE = 2'd2,
    GRANT = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/hermes_route_allocator_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requester found
// after index last_i, wrapping from N-1 back to 0.
module hermes_rr_arbiter #(
  parameter int N = 5,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_valid_o
);

  logic [W-1:0] cand_s;
  logic         hit_s;

  // Scan candidates last+1 .. last+N (mod N) and keep the first one that requests.
  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s      = W'((int'(last_i) + k) % N);
      hit_s       = req_i[cand_s] & ~gnt_valid_o;
      gnt_idx_o   = hit_s ? cand_s : gnt_idx_o;
      gnt_valid_o = gnt_valid_o | hit_s;
    end
  end

endmodule

// File: rtl/hermes_route_allocator.sv
// Hermes router route-and-allocate controller: round-robin selection of a
// waiting header, XY routing, output-port allocation and crossbar selects.
module hermes_route_allocator
  import hermes_route_allocator_pkg::*;
#(
  parameter logic [15:0] ADDRESS   = 16'h0000,
  parameter int          FLIT_SIZE = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic         [HERMES_NPORT-1:0]        req_i,
  input  logic         [HERMES_NPORT-1:0][FLIT_SIZE-1:0] data_i,
  output logic         [HERMES_NPORT-1:0]        ack_o,
  input  logic         [HERMES_NPORT-1:0]        release_i,
  output logic         [HERMES_NPORT-1:0]        free_o,
  output hermes_port_t [HERMES_NPORT-1:0]        inport_o,
  output hermes_port_t [HERMES_NPORT-1:0]        outport_o
);

  alloc_state_t                          state_q, state_d;
  logic         [HERMES_PW-1:0]          sel_q, sel_d;
  logic         [HERMES_PW-1:0]          rr_last_q, rr_last_d;
  hermes_port_t                          dst_q, dst_d;
  logic         [HERMES_NPORT-1:0]       ack_q, ack_d;
  logic         [HERMES_NPORT-1:0]       free_q, free_d;
  logic         [HERMES_NPORT-1:0]       busy_q, busy_d;
  hermes_port_t [HERMES_NPORT-1:0]       inport_q, inport_d;
  hermes_port_t [HERMES_NPORT-1:0]       outport_q, outport_d;

  logic         [HERMES_NPORT-1:0]       elig_s;
  logic         [HERMES_NPORT-1:0]       rel_s;
  logic         [HERMES_NPORT-1:0]       sel_oh_s;
  logic         [HERMES_PW-1:0]          gnt_idx_s;
  logic                                  gnt_valid_s;
  hermes_port_t                          route_dst_s;
  logic                                  unused_payload_s;

  // XY routing: resolve X first, then Y; equal coordinates mean the local port.
  function automatic hermes_port_t xy_route(input logic [15:0] dest);
    logic [7:0]   tx;
    logic [7:0]   ty;
    hermes_port_t dir;
    tx = dest[15:8];
    ty = dest[7:0];
    if (tx > ADDRESS[15:8]) begin
      dir = EAST;
    end else if (tx < ADDRESS[15:8]) begin
      dir = WEST;
    end else if (ty > ADDRESS[7:0]) begin
      dir = NORTH;
    end else if (ty < ADDRESS[7:0]) begin
      dir = SOUTH;
    end else begin
      dir = LOCAL;
    end
    return dir;
  endfunction

  assign elig_s      = req_i & ~busy_q;
  assign rel_s       = release_i & ~free_q;
  assign sel_oh_s    = {{(HERMES_NPORT-1){1'b0}}, 1'b1} << sel_q;
  assign route_dst_s = xy_route(data_i[sel_q][15:0]);

  hermes_rr_arbiter #(.N(HERMES_NPORT)) u_arb (
    .req_i       (elig_s),
    .last_i      (rr_last_q),
    .gnt_idx_o   (gnt_idx_s),
    .gnt_valid_o (gnt_valid_s)
  );

  // Only the header destination field is routed on; fold the rest away.
  always_comb begin
    unused_payload_s = 1'b0;
    for (int i = 0; i < HERMES_NPORT; i++) begin
      unused_payload_s = unused_payload_s ^ (^data_i[i][FLIT_SIZE-1:16]);
    end
  end

  // Next-state logic: releases first, then the arbitrate/route/grant sequence.
  // A grant or failed route chains straight into ARB while other work waits.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    dst_d     = dst_q;
    ack_d     = '0;
    free_d    = free_q | rel_s;
    busy_d    = busy_q;
    inport_d  = inport_q;
    outport_d = outport_q;
    for (int p = 0; p < HERMES_NPORT; p++) begin
      busy_d[inport_q[p]] = busy_d[inport_q[p]] & ~rel_s[p];
    end
    case (state_q)
      IDLE: begin
        state_d = (|elig_s) ? ARB : IDLE;
      end
      ARB: begin
        if (gnt_valid_s) begin
          sel_d     = gnt_idx_s;
          rr_last_d = gnt_idx_s;
          state_d   = ROUTE;
        end else begin
          state_d   = IDLE;
        end
      end
      ROUTE: begin
        if (free_q[route_dst_s]) begin
          dst_d         = route_dst_s;
          ack_d[sel_q]  = 1'b1;
          state_d       = GRANT;
        end else begin
          state_d       = (|elig_s) ? ARB : IDLE;
        end
      end
      GRANT: begin
        free_d[dst_q]    = 1'b0;
        inport_d[dst_q]  = hermes_port_t'(sel_q);
        outport_d[sel_q] = dst_q;
        busy_d[sel_q]    = 1'b1;
        state_d          = (|(elig_s & ~sel_oh_s)) ? ARB : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Allocation table, round-robin pointer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q     <= 3'd0;
      rr_last_q <= 3'(HERMES_NPORT - 1);
      dst_q     <= EAST;
      ack_q     <= '0;
      free_q    <= '1;
      busy_q    <= '0;
      for (int p = 0; p < HERMES_NPORT; p++) begin
        inport_q[p]  <= EAST;
        outport_q[p] <= EAST;
      end
    end else begin
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      dst_q     <= dst_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      busy_q    <= busy_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
    end
  end

  assign ack_o     = ack_q;
  assign free_o    = free_q;
  assign inport_o  = inport_q;
  assign outport_o = outport_q;

endmodule
